// File: rtl/counter_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : counter_bus_writer
// Brief    : Writes one digit over a private half-duplex number bus to a
//            counter, pulsing set/load_en. With COUNTER_BUS_WRITER_READBACK_EN
//            defined, it then releases the bus and checks the captured value.
// Revision : 1.0 - initial release
// ============================================================================
module counter_bus_writer #(
    parameter int BASE           = 10,
    parameter int NUMBER_OF_BITS = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_BITS     = 2,
    parameter int SETTLE_CYCLES  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [DIGIT_BITS-1:0]                req_digit,
    input  logic [NUMBER_OF_BITS-1:0]            req_value,
    inout  wire  [NUM_DIGITS*NUMBER_OF_BITS-1:0] number,
    output logic [NUM_DIGITS-1:0]                set,
    output logic [NUM_DIGITS-1:0]                load_en,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_IDLE    = 3'd0;
    localparam logic [c_ST_W-1:0] c_DRIVE   = 3'd1;
    localparam logic [c_ST_W-1:0] c_RELEASE = 3'd2;
    localparam logic [c_ST_W-1:0] c_VERIFY  = 3'd3;
    localparam logic [c_ST_W-1:0] c_RESP    = 3'd4;

    localparam int c_CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SETTLE_CYCLES);

    logic [c_ST_W-1:0]         r_state;
    logic [c_ST_W-1:0]         w_state_next;
    logic [NUM_DIGITS-1:0]     r_set;
    logic [NUMBER_OF_BITS-1:0] r_value;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_reject;
    logic                      w_req_ok;
    logic                      w_accept;
    logic                      w_drive_last;
    logic [NUM_DIGITS-1:0]     w_onehot;

    assign w_req_ok     = (32'(req_digit) < 32'(NUM_DIGITS)) && (32'(req_value) < 32'(BASE));
    assign w_accept     = req_valid && (r_state == c_IDLE);
    assign w_drive_last = (r_cnt == c_LAST);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_onehot[i] = (req_digit == DIGIT_BITS'(i));
        end
    end

`ifdef COUNTER_BUS_WRITER_READBACK_EN
    logic [DIGIT_BITS-1:0]     r_digit;
    logic                      r_mismatch;
    logic [NUMBER_OF_BITS-1:0] w_sample;

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit == DIGIT_BITS'(i)) begin
                w_sample = number[i*NUMBER_OF_BITS +: NUMBER_OF_BITS];
            end
        end
    end

    // Written as if/else so an unknown or floating readback lands on mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit    <= '0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_digit    <= req_digit;
            r_mismatch <= 1'b0;
        end else if (r_state == c_VERIFY) begin
            if (w_sample == r_value) begin
                r_mismatch <= 1'b0;
            end else begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign err = (r_state == c_RESP) && (r_reject || r_mismatch);
`else
    assign err = (r_state == c_RESP) && r_reject;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_set    <= '0;
            r_value  <= '0;
            r_cnt    <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_value  <= req_value;
                r_reject <= !w_req_ok;
                r_set    <= w_req_ok ? w_onehot : '0;
                r_cnt    <= '0;
            end else if (r_state == c_DRIVE) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (w_drive_last) begin
                    r_set <= '0;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_req_ok ? c_DRIVE : c_RESP;
                end
            end
            c_DRIVE: begin
                if (w_drive_last) begin
`ifdef COUNTER_BUS_WRITER_READBACK_EN
                    w_state_next = c_RELEASE;
`else
                    w_state_next = c_RESP;
`endif
                end
            end
            c_RELEASE: w_state_next = c_VERIFY;
            c_VERIFY:  w_state_next = c_RESP;
            c_RESP:    w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
    end

    assign req_ready = (r_state == c_IDLE);
    assign busy      = !req_ready;
    assign done      = (r_state == c_RESP);
    assign set       = r_set;
    assign load_en   = r_set;

    // Drive enable is the set register itself, so bus and set switch on one edge.
    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bus
            assign number[g*NUMBER_OF_BITS +: NUMBER_OF_BITS] =
                r_set[g] ? r_value : {NUMBER_OF_BITS{1'bz}};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_counter_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_bus_writer
// Brief    : Self-checking bench for counter_bus_writer with counter models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_bus_writer;

    localparam int c_S = 1;
`ifdef COUNTER_BUS_WRITER_READBACK_EN
    localparam bit c_RB = 1'b1;
`else
    localparam bit c_RB = 1'b0;
`endif
    localparam int c_OFF_VALID = c_RB ? c_S + 3 : c_S + 1;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_digit = 2'd0;
    logic [3:0]  req_value = 4'd0;
    wire  [15:0] number;
    logic [3:0]  set, load_en;
    logic        req_ready, busy, done, err;

    logic [3:0]  cnt [4] = '{default: 4'd0};
    logic        fault [4] = '{default: 1'b0};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_q[$];

    typedef struct {
        int         exp_cyc;
        logic       err;
        int         digit;
        logic [3:0] value;
        int         exp_drives;
        int         drives;
        bit         rej;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [1:0] d;
        logic [3:0] v;
        logic       f;
        logic [3:0] exp_cnt;
    } vec_t;
    vec_t vt[8];

    counter_bus_writer #(
        .BASE(10), .NUMBER_OF_BITS(4), .NUM_DIGITS(4), .DIGIT_BITS(2), .SETTLE_CYCLES(c_S)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_digit(req_digit), .req_value(req_value), .number(number),
        .set(set), .load_en(load_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Counter models: drive their value whenever set is low, capture on load_en.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_cnt
            assign number[g*4 +: 4] = set[g] ? 4'bz : cnt[g];
            always @(posedge clk) begin
                if (load_en[g]) cnt[g] <= fault[g] ? 4'd0 : number[g*4 +: 4];
            end
        end
    endgenerate

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        sb_t e;
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
        end else if (req_valid && req_ready) begin
            e.rej        = (req_value >= 4'd10);
            e.digit      = int'(req_digit);
            e.value      = req_value;
            e.drives     = 0;
            e.err        = e.rej | (c_RB & fault[req_digit]);
            e.exp_cyc    = cyc + (e.rej ? 0 : c_OFF_VALID);
            e.exp_drives = e.rej ? 0 : c_S + 1;
            sb.push_back(e);
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (sb.size() > 0 && set != 4'd0) begin
                chk("set_onehot", int'(set), 1 << sb[0].digit);
                chk("load_en_eq_set", int'(load_en), int'(set));
                chk("bus_value", int'(number[sb[0].digit*4 +: 4]), int'(sb[0].value));
                sb[0].drives++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.exp_cyc);
                    chk("done_err", int'(err), int'(e.err));
                    chk("drive_cycles", e.drives, e.exp_drives);
                    if (!e.rej) chk("bus_released", int'(number[e.digit*4 +: 4]), int'(cnt[e.digit]));
                end
            end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                chk("missing_done", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic write_req(input logic [1:0] d, input logic [3:0] v);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_digit = d;
        req_value = v;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !req_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int base;
        int n;
        vt[0] = '{2'd2, 4'd7,  1'b0, 4'd7};
        vt[1] = '{2'd0, 4'd10, 1'b0, 4'd0};
        vt[2] = '{2'd3, 4'd9,  1'b1, 4'd0};
        vt[3] = '{2'd1, 4'd15, 1'b0, 4'd0};
        vt[4] = '{2'd0, 4'd9,  1'b0, 4'd9};
        vt[5] = '{2'd1, 4'd0,  1'b0, 4'd0};
        vt[6] = '{2'd1, 4'd4,  1'b1, 4'd0};
        vt[7] = '{2'd3, 4'd5,  1'b0, 4'd5};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_set", int'(set), 0);
        chk("rst_load_en", int'(load_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fault[vt[i].d] = vt[i].f;
            write_req(vt[i].d, vt[i].v);
            wait_idle();
            chk("cnt_after_write", int'(cnt[vt[i].d]), int'(vt[i].exp_cnt));
        end

        // Reset during the second drive cycle aborts without a done pulse.
        write_req(2'd2, 4'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_set", int'(set), 0);
        chk("abort_load_en", int'(load_en), 0);
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_done", int'(done), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_cnt", int'(cnt[2]), 3);

        // Held req_valid: second request accepted right after the first completes.
        fault[0] = 1'b0;
        fault[1] = 1'b0;
        base = acc_q.size();
        @(negedge clk);
        req_valid = 1'b1;
        req_digit = 2'd0;
        req_value = 4'd3;
        @(negedge clk);
        req_digit = 2'd1;
        req_value = 4'd5;
        n = 0;
        while (acc_q.size() < base + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        if (acc_q.size() >= base + 2) begin
            chk("requeue_gap", acc_q[base+1] - acc_q[base], c_OFF_VALID + 2);
        end else begin
            chk("requeue_timeout", 0, 1);
        end
        wait_idle();
        chk("held_cnt0", int'(cnt[0]), 3);
        chk("held_cnt1", int'(cnt[1]), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
